// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for a 32-entry register file. It arbitrates ALU and LSU writebacks
// round-robin onto the single write port and keeps a busy scoreboard for RAW/WAW issue stalls.
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 issue_rd_en,
    input  logic [AW-1:0]        issue_rs1,
    input  logic [AW-1:0]        issue_rs2,
    output logic                 issue_stall,

    input  logic                 alu_wb_valid,
    input  logic [AW-1:0]        alu_wb_addr,
    input  logic [XLEN-1:0]      alu_wb_data,
    output logic                 alu_wb_ready,

    input  logic                 lsu_wb_valid,
    input  logic [AW-1:0]        lsu_wb_addr,
    input  logic [XLEN-1:0]      lsu_wb_data,
    output logic                 lsu_wb_ready,

    output logic                 rf_write_enable,
    output logic [AW-1:0]        rf_write_addr,
    output logic [XLEN-1:0]      rf_write_data,

    output logic [(2**AW)-1:0]   busy_mask,
    output logic                 idle
);

    localparam int NREG = 2**AW;

    logic [NREG-1:0] busy_q, busy_d;
    // ptr_q = 0 favours the ALU, 1 favours the LSU
    logic            ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            alu_gnt, lsu_gnt, wb_fire;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            hazard, issue_accept;

    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (!reset) begin
            alu_gnt = alu_wb_valid & (!lsu_wb_valid | !ptr_q);
            lsu_gnt = lsu_wb_valid & (!alu_wb_valid |  ptr_q);
        end
    end

    assign alu_wb_ready = alu_gnt;
    assign lsu_wb_ready = lsu_gnt;
    assign wb_fire      = alu_gnt | lsu_gnt;
    assign wb_addr      = lsu_gnt ? lsu_wb_addr : alu_wb_addr;
    assign wb_data      = lsu_gnt ? lsu_wb_data : alu_wb_data;

    // Hazard uses registered busy state only; a clear in this cycle is not bypassed.
    assign hazard = busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_rd_en & busy_q[issue_rd]);

    always_comb begin
        issue_stall = 1'b1;
        if (!reset) begin
            issue_stall = issue_valid & hazard;
        end
    end

    assign issue_accept = issue_valid & !issue_stall;

    always_comb begin
        busy_d = busy_q;
        if (wb_fire) begin
            busy_d[wb_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle set wins.
        if (issue_accept && issue_rd_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (alu_gnt) begin
            ptr_d = 1'b1;
        end else if (lsu_gnt) begin
            ptr_d = 1'b0;
        end
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        // A grant to x0 is consumed without touching the register file.
        if (wb_fire && (wb_addr != '0)) begin
            we_d    = 1'b1;
            waddr_d = wb_addr;
            wdata_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            ptr_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_write_addr   = waddr_q;
    assign rf_write_data   = wdata_q;
    assign busy_mask       = busy_q;
    assign idle            = (busy_q == '0) & !alu_wb_valid & !lsu_wb_valid & !we_q;

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file and sequences all writebacks into it.
- Round-robin arbitrates between two writeback requesters: ALU and load/store unit (LSU).
- Keeps a per-register busy scoreboard and stalls issue on RAW and WAW hazards against pending writebacks.
- Sits between the issue stage and the execute units on one side, and the register file write port on the other.

Parameters:
- XLEN, 32, data width of register values
- AW, 5, register address width (2**AW registers)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- issue_valid  input  1  issue stage presents an instruction
- issue_rd  input  AW  destination register of issuing instruction
- issue_rd_en  input  1  instruction writes issue_rd
- issue_rs1  input  AW  source register 1
- issue_rs2  input  AW  source register 2
- issue_stall  output  1  issue must hold; instruction not accepted this cycle
- alu_wb_valid  input  1  ALU writeback request
- alu_wb_addr  input  AW  ALU destination register
- alu_wb_data  input  XLEN  ALU result
- alu_wb_ready  output  1  ALU request granted this cycle
- lsu_wb_valid  input  1  LSU writeback request
- lsu_wb_addr  input  AW  LSU destination register
- lsu_wb_data  input  XLEN  load result
- lsu_wb_ready  output  1  LSU request granted this cycle
- rf_write_enable  output  1  register file write enable
- rf_write_addr  output  AW  register file write address
- rf_write_data  output  XLEN  register file write data
- busy_mask  output  2**AW  scoreboard, bit i = register i has a pending write
- idle  output  1  busy_mask==0, no wb_valid asserted, rf_write_enable==0

Behaviour:
- Clock and reset:
  - Single clock clk; reset is synchronous, active-high, sampled on the posedge clk.
  - Reset state: busy_mask=0, rf_write_enable=0, rf_write_addr=0, rf_write_data=0, round-robin pointer favours ALU.
  - While reset is high: alu_wb_ready=0, lsu_wb_ready=0, issue_stall=1.
  - Reset mid-operation drops all pending scoreboard state and any registered write not yet presented.
- Scoreboard:
  - busy_mask bit 0 is hardwired 0.
  - hazard = busy[issue_rs1] | busy[issue_rs2] | (issue_rd_en & busy[issue_rd]), using registered busy state. Same-cycle clears are not bypassed.
  - issue_stall = issue_valid & hazard; issue_stall=0 when issue_valid=0.
  - Issue accepted when issue_valid & !issue_stall. If issue_rd_en and issue_rd!=0, busy[issue_rd] sets on the next edge.
  - A granted writeback clears busy[wb_addr] on the next edge.
  - Set and clear of the same bit in the same cycle: set wins.
  - A writeback to a non-busy register is legal; its clear is a no-op.
- Arbitration:
  - At most one grant per cycle; ready is combinational from the valids and the pointer.
  - Only one valid: that source is granted.
  - Both valid: the source the pointer favours is granted, then the pointer moves to favour the other source.
  - With one source valid, the pointer moves away from the granted source.
  - Requesters hold valid, addr and data stable until ready; a transfer completes when valid & ready.
- Write port:
  - Registered, one-cycle latency: a grant in cycle N gives rf_write_enable=1 with the granted addr/data in cycle N+1.
  - Granted addr==0: the transfer is consumed but rf_write_enable stays 0.
  - No grant: rf_write_enable=0, addr/data hold their previous values.
- Throughput: one writeback per cycle sustained; with both sources continuously valid, grants alternate ALU, LSU, ALU, and so on.

Test Plan:
- Reset, then idle: busy_mask=0, rf_write_enable=0, idle=1, issue_valid=1 rs1=1 rs2=2 -> issue_stall=0.
- Issue rd=5 accepted, next cycle issue rs1=5 -> issue_stall=1. ALU wb addr=5 data=0xDEADBEEF granted at cycle N -> cycle N+1 rf_write_enable=1 addr=5 data=0xDEADBEEF, busy[5]=0, issue_stall drops at N+1.
- ALU and LSU valid together for 4 cycles, addrs 3/4 -> grants ALU, LSU, ALU, LSU. Loser's ready=0 while it holds, and it completes on the next cycle.
- LSU wb addr=0 data=0x1234 -> lsu_wb_ready=1, rf_write_enable stays 0, busy_mask[0]=0 throughout.
- Same cycle: issue rd=7 accepted while a stray ALU wb to addr 7 (not busy) is granted -> busy[7]=1 after the edge (set wins).
- busy[9]=1 with ALU valid, assert reset for 1 cycle -> both readies=0 during reset; after reset busy_mask=0, rf_write_enable=0, pointer favours ALU.
